mem_wb_skid: RTL

Parametrised MEM→WB pipeline boundary: a registered, multi-lane writeback payload with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and hard-zero-register write suppression. It sits between the memory stage and the register file write port. Upstream can stall without a combinational ready path, and a squashed instruction never reaches writeback.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/skid_buf.sv | 82 ++++++++
 rtl/mem_wb_skid.sv | 65 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the slot-occupancy encoding used by the writeback skid buffer.
package cpu_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int ZERO_REG_ADDR = 0;

  // Encoding is {main.valid, skid.valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'b00,
    SLOT_ONE   = 2'b10,
    SLOT_FULL  = 2'b11
  } slot_state_e;

endpackage

// File: rtl/skid_buf.sv
// Generic two-slot valid/ready skid buffer with synchronous flush on a flat payload.
// The ready output is registered, so there is no path from out_ready back to in_ready.
module skid_buf
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  slot_state_e  state_reg, state_next;
  logic [W-1:0] main_reg, main_next;
  logic [W-1:0] skid_reg, skid_next;
  logic         in_ready_reg, in_ready_next;
  logic         in_fire, out_fire;

  assign out_valid = (state_reg == SLOT_ONE) || (state_reg == SLOT_FULL);
  assign out_data  = main_reg;
  assign in_ready  = in_ready_reg;
  assign in_fire   = in_valid & in_ready_reg;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    // Payload registers are left untouched on flush so outputs keep their last value.
    if (flush) begin
      state_next = SLOT_EMPTY;
    end else begin
      case (state_reg)
        SLOT_EMPTY: begin
          if (in_fire) begin
            main_next  = in_data;
            state_next = SLOT_ONE;
          end
        end
        SLOT_ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            skid_next  = in_data;
            state_next = SLOT_FULL;
          end else if (out_fire) begin
            state_next = SLOT_EMPTY;
          end
        end
        SLOT_FULL: begin
          if (out_fire) begin
            main_next  = skid_reg;
            state_next = SLOT_ONE;
          end
        end
        default: state_next = SLOT_EMPTY;
      endcase
    end
    in_ready_next = (state_next != SLOT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SLOT_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
    end
  end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM->WB boundary: multi-lane writeback payload through a skid buffer, with
// zero-register write suppression at capture and valid gating of the enables.
module mem_wb_skid
  import cpu_pkg::*;
#(
  parameter int LANES    = 1,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = XLEN,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         rd_we_i,
  input  logic [LANES*ADDR_W-1:0]  rd_addr_i,
  input  logic [LANES*DATA_W-1:0]  rd_data_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         rd_we,
  output logic [LANES*ADDR_W-1:0]  rd_addr,
  output logic [LANES*DATA_W-1:0]  rd_data
);

  localparam int LANE_W = 1 + ADDR_W + DATA_W;
  localparam int W      = LANES * LANE_W;

  logic [W-1:0]     pack_in, pack_out;
  logic [LANES-1:0] we_masked, we_held;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ADDR_W-1:0] lane_addr;
      assign lane_addr = rd_addr_i[gi*ADDR_W +: ADDR_W];

      if (ZERO_REG != 0) begin : g_zero
        assign we_masked[gi] = rd_we_i[gi] & (lane_addr != ADDR_W'(ZERO_REG_ADDR));
      end else begin : g_nozero
        assign we_masked[gi] = rd_we_i[gi];
      end

      assign pack_in[gi*LANE_W +: LANE_W] =
        {we_masked[gi], lane_addr, rd_data_i[gi*DATA_W +: DATA_W]};
      assign {we_held[gi], rd_addr[gi*ADDR_W +: ADDR_W], rd_data[gi*DATA_W +: DATA_W]} =
        pack_out[gi*LANE_W +: LANE_W];
      assign rd_we[gi] = we_held[gi] & out_valid;
    end
  endgenerate

  skid_buf #(
    .W(W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pack_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pack_out)
  );

endmodule
